// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between the FIFO user logic and fifo_ctrl.
// The master side issues wr/rd requests. The slave side (the controller)
// returns the RAM controls and the occupancy flags.
// Optional signals: almost_full/almost_empty, present when
// FIFO_CTRL_ALMOST_EN is defined.
interface fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  wr;
    logic                  rd;
    logic                  we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
`ifdef FIFO_CTRL_ALMOST_EN
    logic                  almost_full;
    logic                  almost_empty;

    modport master (
        output wr, rd,
        input  we, w_addr, r_addr, full, empty, count, overflow, underflow,
               almost_full, almost_empty
    );

    modport slave (
        input  wr, rd,
        output we, w_addr, r_addr, full, empty, count, overflow, underflow,
               almost_full, almost_empty
    );
`else
    modport master (
        output wr, rd,
        input  we, w_addr, r_addr, full, empty, count, overflow, underflow
    );

    modport slave (
        input  wr, rd,
        output we, w_addr, r_addr, full, empty, count, overflow, underflow
    );
`endif
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a synchronous FIFO built on a two-port RAM.
// The RAM has a registered write and a combinational read.
// The depth need not be a power of two: the pointers wrap at DEPTH-1.
// full/empty are decoded from the registered occupancy count, not from
// pointer equality.
// Optional feature: FIFO_CTRL_ALMOST_EN adds registered almost_full and
// almost_empty flags.
module fifo_ctrl #(
    parameter int ADDR_WIDTH      = 4,
    parameter int DEPTH           = 13,
    parameter int ALMOST_FULL_TH  = 11,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    fifo_ctrl_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_ok;
    logic                  wr_ok;

    // A write into a full FIFO is accepted only when a read frees a slot in
    // the same cycle.
    assign rd_ok = bus.rd & ~empty_q;
    assign wr_ok = bus.wr & (~full_q | rd_ok);

    // Next-state for the pointers, count, decoded flags and error pulses.
    always_comb begin
        w_addr_d    = w_addr_q;
        r_addr_d    = r_addr_q;
        count_d     = count_q;

        if (wr_ok) begin
            w_addr_d = (w_addr_q == LAST_ADDR) ? '0 : w_addr_q + 1'b1;
        end
        if (rd_ok) begin
            r_addr_d = (r_addr_q == LAST_ADDR) ? '0 : r_addr_q + 1'b1;
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d      = (count_d == DEPTH_CNT);
        empty_d     = (count_d == '0);
        overflow_d  = bus.wr & ~wr_ok;
        underflow_d = bus.rd & ~rd_ok;
    end

    // State registers; reset leaves the FIFO empty with both pointers at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_addr_q    <= '0;
            r_addr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_addr_q    <= w_addr_d;
            r_addr_q    <= r_addr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.we        = wr_ok;
    assign bus.w_addr    = w_addr_q;
    assign bus.r_addr    = r_addr_q;
    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

`ifdef FIFO_CTRL_ALMOST_EN
    localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH + 1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0] AE_CNT = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_TH);

    logic almost_full_q;
    logic almost_empty_q;

    // Threshold flags registered alongside count so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= (count_d >= AF_CNT);
            almost_empty_q <= (count_d <= AE_CNT);
        end
    end

    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
`endif

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller for the synchronous FIFO. It drives the write enable and the write and read addresses of the two-port RAM, which has a registered write and a combinational read. It also keeps the occupancy count and the full/empty status for a depth that need not be a power of two (13 entries in the standard build). The user logic presents write and read requests and sees the head word directly on the RAM read-data output.

## Interface
Parameters:
- ADDR_WIDTH, 4, address bits into the RAM; must satisfy 2**ADDR_WIDTH >= DEPTH
- DEPTH, 13, number of usable entries, 2..2**ADDR_WIDTH
- ALMOST_FULL_TH, 11, almost_full asserted when count >= this value
- ALMOST_EMPTY_TH, 2, almost_empty asserted when count <= this value

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock shared with the RAM
- rst_n  in  1  asynchronous active-low reset
- wr  in  1  write request; w_data is presented to the RAM in the same cycle
- rd  in  1  read request; the head word on r_data is consumed this cycle
- we  out  1  RAM write enable, combinational: wr & write_accepted
- w_addr  out  ADDR_WIDTH  RAM write address, registered
- r_addr  out  ADDR_WIDTH  RAM read address (head), registered
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: wr while the write was rejected
- underflow  out  1  one-cycle pulse: rd while the read was rejected
- almost_full, almost_empty  out  1  present only with FIFO_CTRL_ALMOST_EN

## Operation
- Acceptance rules:
  - rd_ok = rd & !empty
  - wr_ok = wr & (!full | rd_ok); a write while full is accepted only if a read is accepted in the same cycle.
- Pointer advance:
  - On wr_ok, w_addr advances: it becomes 0 if it equals DEPTH-1, otherwise it increments by 1.
  - On rd_ok, r_addr advances with the same rule.
  - Values DEPTH..2**ADDR_WIDTH-1 are never produced.
- Count update:
  - +1 on wr_ok only; -1 on rd_ok only.
  - No change when both or neither are accepted.
  - full and empty are decoded from the registered count, never from pointer equality.
- Full with wr and rd both high: both are accepted. The head is read combinationally before the edge, and the write lands in the slot just freed (w_addr == r_addr). The count stays at DEPTH.
- Empty with wr and rd both high: only the write is accepted. underflow pulses and the count becomes 1.
- Flag pulses:
  - overflow = wr & !wr_ok, registered.
  - underflow = rd & !rd_ok, registered.
  - Both pulse for exactly one cycle per offending cycle.
- r_data is valid whenever empty is 0. When empty is 1 it shows stale RAM content and must be ignored.

## Timing
- Reset (rst_n low, asynchronous): w_addr=0, r_addr=0, count=0, empty=1, full=0, overflow=0, underflow=0, almost_empty=1, almost_full=0.
- Reset asserted mid-operation clears all state immediately. RAM contents are not cleared and are never observed, since the FIFO reads as empty after reset.
- Write-to-read latency: a word written at edge N is visible on r_data after edge N while empty=0. A word written into an empty FIFO is readable in cycle N+1.
- Flags, count and pointers all change only on the rising edge; we is the only combinational output.
- overflow and underflow appear one cycle after the offending request.

## Configuration
- FIFO_CTRL_ALMOST_EN defined:
  - almost_full = (count >= ALMOST_FULL_TH) and almost_empty = (count <= ALMOST_EMPTY_TH) exist as ports.
  - Both are registered alongside count.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset then idle: after rst_n rises → empty=1, full=0, count=0, w_addr=0, r_addr=0, we=0.
- 13 consecutive writes (0x01..0x0D) → full=1 after the 13th edge, count=13, w_addr=0. A 14th write → we=0, overflow pulses once, count stays 13.
- Drain 13 reads → r_data sequence 0x01..0x0D in order, empty=1, r_addr=0. A further read → underflow pulses once.
- Wrap: write 10, read 10, write 5 → w_addr sequence passes 12→0. Reads return the 5 new words in order and count ends at 0.
- Simultaneous wr+rd when full (count=13) → head read correctly, new word stored, count=13, both pointers advance by 1. Simultaneous wr+rd when empty → count=1, underflow=1.
- With FIFO_CTRL_ALMOST_EN: fill to 11 → almost_full=1 at count 11 and 0 at 10. Drain to 2 → almost_empty=1.
